// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the buffered 1-to-2 stream demultiplexer.
//   SEL_OUT1 / SEL_OUT2 : in_sel encodings. These match the sense of the
//                         datapath 2:1 mux select.
//   SLOT_WIDTH          : default word width that slot_t is built on.
//   slot_t              : one buffered output entry (valid flag plus word).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package stream_demux_pkg;

    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    localparam int SLOT_WIDTH = 32;

    typedef struct packed {
        logic                  valid;
        logic [SLOT_WIDTH-1:0] data;
    } slot_t;

endpackage

// File: rtl/stream_demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// A one-entry registered output slot for stream_demux. It holds a single word
// and presents it to a consumer through a valid/ready handshake.
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   load     in   1      capture data_in this cycle (already qualified)
//   data_in  in   WIDTH  word to capture
//   ready    in   1      consumer takes the held word
//   valid    out  1      slot holds a word
//   data     out  WIDTH  held word
//   can_load out  1      slot can take a new word this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = SLOT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_load
);

    // The slot can take a word when it is empty or when its word leaves on
    // this same edge. This is what allows a full rate of one word per cycle.
    assign can_load = !valid || ready;

    // Load has priority over drain. When both happen on the same edge, the
    // new word replaces the departing one and valid stays high. A plain drain
    // clears valid but keeps the data, so the output does not toggle for no
    // reason.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Buffered 1-to-2 demultiplexer. It steers one valid/ready word stream to one
// of two consumers. Each output has its own one-entry registered slot, so
// back-pressure on one output never blocks words headed for the other.
// The optional per-output accept counters are enabled by defining the macro
// STREAM_DEMUX_CNT_EN.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   cnt_clr    in   1      synchronous clear of cnt1/cnt2 (STREAM_DEMUX_CNT_EN)
//   cnt1/cnt2  out  CNT_W  words accepted for out1/out2 (STREAM_DEMUX_CNT_EN)
//   in_data    in   WIDTH  input word
//   in_sel     in   1      0 -> out1, 1 -> out2
//   in_valid   in   1      input word present
//   in_ready   out  1      word is accepted this cycle
//   outN_data  out  WIDTH  slot N word
//   outN_valid out  1      slot N holds a word
//   outN_ready in   1      consumer N takes the word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef STREAM_DEMUX_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
);

    logic can_load1;
    logic can_load2;
    logic load1;
    logic load2;

    // Reject unusable counter widths at elaboration time.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("stream_demux: CNT_W must be at least 1");
    end

    // in_ready depends only on the selected slot. in_valid is deliberately
    // left out, so there is no combinational loop back to a producer that
    // waits for ready before raising valid.
    assign in_ready = (in_sel == SEL_OUT2) ? can_load2 : can_load1;

    assign load1 = in_valid && in_ready && (in_sel == SEL_OUT1);
    assign load2 = in_valid && in_ready && (in_sel == SEL_OUT2);

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load1),
        .data_in  (in_data),
        .ready    (out1_ready),
        .valid    (out1_valid),
        .data     (out1_data),
        .can_load (can_load1)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load2),
        .data_in  (in_data),
        .ready    (out2_ready),
        .valid    (out2_valid),
        .data     (out2_data),
        .can_load (can_load2)
    );

`ifdef STREAM_DEMUX_CNT_EN
    // Each counter counts the accepts routed to its output and wraps freely.
    // A clear wins over an increment on the same edge, so software sees zero
    // right after a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else if (cnt_clr) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (load1) cnt1 <= cnt1 + CNT_W'(1);
            if (load2) cnt2 <= cnt2 + CNT_W'(1);
        end
    end
`endif

endmodule
